avalon_pio_irq: RTL
===================

// Module: avalon_pio_irq
// PURPOSE
//  Parametrised Avalon-MM PIO with input synchroniser, per-bit debounce, edge capture, maskable IRQ
//  and atomic set/clear output registers. Next-generation replacement for the fixed 4/8-bit
//  button/dipsw/led/pio_N instances in soc_system; one instance per input/output bank on the
//  lightweight HPS-to-FPGA bridge.
// PARAMETERS
//  IN_WIDTH        8      input bits, 1..32
//  OUT_WIDTH       8      output bits, 1..32
//  DEBOUNCE_CYCLES 50000  consecutive stable cycles before a debounced bit changes; >=1, 1 = no filter
//  EDGE_MODE       0      0 rising, 1 falling, 2 any edge sets capture bit
//  OUT_RESET       0      reset value of pio_out (OUT_WIDTH bits)
// PORTS
//  clk_clk        in   1          single clock, all logic
//  reset_reset_n  in   1          asynchronous active-low reset
//  avs_address    in   3          word address
//  avs_read       in   1          read strobe
//  avs_write      in   1          write strobe
//  avs_writedata  in   32         write data
//  avs_readdata   out  32         read data, valid 1 cycle after avs_read
//  pio_in         in   IN_WIDTH   asynchronous external inputs
//  pio_out        out  OUT_WIDTH  registered outputs
//  irq            out  1          level interrupt, registered
// BEHAVIOUR
//  Reset: sync/debounced/prev regs 0, counters 0, edge_cap 0, irq_mask 0, pio_out=OUT_RESET,
//   avs_readdata 0, irq 0. Reset mid-operation aborts everything; no state survives.
//  Register map (no waitrequest, fixed read latency 1):
//   0 DATA     R: debounced inputs          W: pio_out <= wdata
//   1 OUT_SET  R: 0                         W: pio_out <= pio_out | wdata
//   2 OUT_CLR  R: 0                         W: pio_out <= pio_out & ~wdata
//   3 IRQ_MASK R/W mask, IN_WIDTH bits
//   4 EDGE_CAP R: capture bits              W: write-1-to-clear
//   5 OUT_RB   R: pio_out                   W: ignored
//   6,7        R: 0                         W: ignored
//  Bits above IN_WIDTH/OUT_WIDTH read 0, ignored on write.
//  avs_read and avs_write both asserted: write performed, readdata from pre-write state.
//  Synchroniser: 2 flops per bit, no reset bypass.
//  Debounce per bit i: cnt<=0 when sync==deb; else if cnt==DEBOUNCE_CYCLES-1 {deb<=sync; cnt<=0}
//   else cnt++. Counter width $clog2(DEBOUNCE_CYCLES)+1. A glitch shorter than DEBOUNCE_CYCLES
//   cycles never reaches deb. Latency pin->deb = 2+DEBOUNCE_CYCLES edges.
//  Edge detect: prev<=deb each cycle; edge=(deb&~prev | ~deb&prev per EDGE_MODE).
//   Edge in same cycle as W1C of same bit: set wins (no lost event). edge_cap sets 1 cycle after deb.
//  irq <= |(edge_cap & irq_mask), 1 cycle after edge_cap/mask update. Unmasking a pending bit
//   raises irq next cycle; masking drops it next cycle; edge_cap unchanged by mask.
//  Input held high through reset: deb rises after 2+DEBOUNCE_CYCLES edges, rising capture set
//   (software clears EDGE_CAP after init).
//  OUT_SET/OUT_CLR back-to-back: each applied in its own cycle, no lost bits.
// TESTING
//  1 Reset OUT_RESET=8'hA5: pio_out=A5, irq=0, read addr4 -> 0, addr5 -> 000000A5.
//  2 DEBOUNCE_CYCLES=4: pin0 high 3 cycles then low -> DATA stays 0; high 4+ cycles -> DATA bit0=1
//    at edge 6 after pin change, EDGE_CAP=1 next cycle.
//  3 Mask=1, rising edge bit0 -> irq=1 two cycles after deb; W1C addr4 wdata=1 -> irq=0 next+1.
//  4 W1C of bit2 in same cycle as new bit2 edge -> EDGE_CAP bit2 stays 1, irq stays high.
//  5 pio_out=00: write SET 0x0F, CLR 0x05 back-to-back -> 0x0F then 0x0A; write 0xFFFF_FF00 -> 00.
//  6 Assert reset_reset_n low mid-debounce with edge_cap=FF -> all regs 0 asynchronously, irq=0.

Source files
------------

// File: rtl/avalon_pio_irq.sv
// Avalon-MM PIO bank: synchronised, debounced inputs with edge capture and a maskable
// level interrupt, plus write/set/clear output register with readback.
module avalon_pio_irq #(
  parameter int                     IN_WIDTH        = 8,
  parameter int                     OUT_WIDTH       = 8,
  parameter int                     DEBOUNCE_CYCLES = 50000,
  parameter int                     EDGE_MODE       = 0,
  parameter logic [OUT_WIDTH-1:0]   OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out,
  output logic                 irq
);

  localparam int             CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  TC = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_OUT_SET  = 3'd1;
  localparam logic [2:0] A_OUT_CLR  = 3'd2;
  localparam logic [2:0] A_IRQ_MASK = 3'd3;
  localparam logic [2:0] A_EDGE_CAP = 3'd4;
  localparam logic [2:0] A_OUT_RB   = 3'd5;

  logic [IN_WIDTH-1:0] sync1, sync2;
  logic [IN_WIDTH-1:0] deb, prev;
  logic [CW-1:0]       cnt [IN_WIDTH];
  logic [IN_WIDTH-1:0] edge_cap, irq_mask, edge_det, cap_clr;
  logic [IN_WIDTH-1:0] wdata_in;
  logic [OUT_WIDTH-1:0] wdata_out;

  assign wdata_in  = avs_writedata[IN_WIDTH-1:0];
  assign wdata_out = avs_writedata[OUT_WIDTH-1:0];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pio_in;
      sync2 <= sync1;
    end
  end

  // A bit only follows the synchronised input after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TC) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_MODE)
      0:       edge_det = deb & ~prev;
      1:       edge_det = ~deb & prev;
      default: edge_det = (deb & ~prev) | (~deb & prev);
    endcase
  end

  assign cap_clr = (avs_write && avs_address == A_EDGE_CAP) ? wdata_in : '0;

  // New edges are ORed in after the clear so a simultaneous W1C never loses an event.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev     <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= deb;
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
      irq      <= |(edge_cap & irq_mask);
      if (avs_write && avs_address == A_IRQ_MASK) irq_mask <= wdata_in;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pio_out <= OUT_RESET;
    end else if (avs_write) begin
      case (avs_address)
        A_DATA:    pio_out <= wdata_out;
        A_OUT_SET: pio_out <= pio_out | wdata_out;
        A_OUT_CLR: pio_out <= pio_out & ~wdata_out;
        default:   pio_out <= pio_out;
      endcase
    end
  end

  // Read data is taken from register state before any same-cycle write lands.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        A_DATA:     avs_readdata <= 32'(deb);
        A_IRQ_MASK: avs_readdata <= 32'(irq_mask);
        A_EDGE_CAP: avs_readdata <= 32'(edge_cap);
        A_OUT_RB:   avs_readdata <= 32'(pio_out);
        default:    avs_readdata <= '0;
      endcase
    end
  end

endmodule
